// File: rtl/comp_buscador_pkg.sv
// Shared definitions for the comp_buscador binary-search initiator.
//   state_t  : FSM encoding (IDLE=0, SEARCH=1, DONE=2, ERR=3)
//   flags_ok : true when exactly one comparator flag is high
package comp_buscador_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    // A well-behaved three-way comparator asserts exactly one of its flags.
    function automatic logic flags_ok(input logic mayor, input logic igual, input logic menor);
        logic ok;
        case ({mayor, igual, menor})
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/comp_buscador_if.sv
// Bus between the search initiator and an external magnitude comparator,
// plus the search control/status signals.
//   start                : request a new search
//   mayor / igual / menor: comparator flags (a > b, a == b, a < b)
//   guess                : value driven to the comparator b input
//   busy / done / error  : status, mutually exclusive
//   result / steps       : located value and comparison count
//   state                : FSM state, exposed for observation
// Handshake: start is a level sampled on the rising edge while the initiator
// is not busy; comparator flags are sampled every SEARCH cycle against the
// guess that has been stable since the previous edge.
// Modports: master = the initiator, slave = the environment/comparator side.
interface comp_buscador_if #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 2)
);
    import comp_buscador_pkg::*;

    logic          start;
    logic          mayor;
    logic          igual;
    logic          menor;
    logic [N-1:0]  guess;
    logic          busy;
    logic          done;
    logic          error;
    logic [N-1:0]  result;
    logic [CW-1:0] steps;
    state_t        state;

    modport master (
        input  start, mayor, igual, menor,
        output guess, busy, done, error, result, steps, state
    );

    modport slave (
        output start, mayor, igual, menor,
        input  guess, busy, done, error, result, steps, state
    );

endinterface

// File: rtl/comp2.sv
// Two-bit combinational magnitude comparator (Comp2 style).
//   a, b  : operands
//   mayor : a > b
//   igual : a == b
//   menor : a < b
module comp2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       mayor,
    output logic       igual,
    output logic       menor
);

    assign mayor = (a > b);
    assign igual = (a == b);
    assign menor = (a < b);

endmodule

// File: rtl/comp_buscador.sv
// Sequential binary-search initiator. Drives guesses to the b side of an
// external comparator and narrows the interval [lo, hi] from the returned
// flags until the comparator reports equality.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : comp_buscador_if master modport (start, flags in; guess, status,
//         result, steps and state out)
module comp_buscador
    import comp_buscador_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 2)
) (
    input  logic             clk,
    input  logic             rst,
    comp_buscador_if.master  bus
);

    localparam int W = N + 1;
    // First probe is 2^(N-1)-1, the lower midpoint of [0, 2^N-1].
    localparam logic [N-1:0] FIRST_GUESS = {1'b0, {(N-1){1'b1}}};

    state_t        state_q, state_n;
    logic [N-1:0]  guess_q, guess_n;
    logic [N-1:0]  result_q, result_n;
    logic [CW-1:0] steps_q, steps_n;
    logic [N-1:0]  lo_q, lo_n;
    logic [N-1:0]  hi_q, hi_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '1;
        end else begin
            state_q  <= state_n;
            guess_q  <= guess_n;
            result_q <= result_n;
            steps_q  <= steps_n;
            lo_q     <= lo_n;
            hi_q     <= hi_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        guess_n  = guess_q;
        result_n = result_q;
        steps_n  = steps_q;
        lo_n     = lo_q;
        hi_n     = hi_q;

        case (state_q)
            SEARCH: begin
                steps_n = steps_q + CW'(1);
                if (!flags_ok(bus.mayor, bus.igual, bus.menor)) begin
                    state_n = ERR;
                end else if (bus.igual) begin
                    state_n  = DONE;
                    result_n = guess_q;
                end else if (bus.mayor) begin
                    // Nothing above hi left to try: comparator is inconsistent.
                    if (guess_q == hi_q) begin
                        state_n = ERR;
                    end else begin
                        lo_n    = guess_q + N'(1);
                        // Sum in N+1 bits so guess+1+hi cannot wrap.
                        guess_n = N'(({1'b0, guess_q} + W'(1) + {1'b0, hi_q}) >> 1);
                    end
                end else begin
                    // Nothing below lo left to try; also keeps guess-1 from underflowing.
                    if (guess_q == lo_q) begin
                        state_n = ERR;
                    end else begin
                        hi_n    = guess_q - N'(1);
                        guess_n = N'(({1'b0, lo_q} + {1'b0, guess_q} - W'(1)) >> 1);
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERR all accept a new search request.
                if (bus.start) begin
                    state_n  = SEARCH;
                    lo_n     = '0;
                    hi_n     = '1;
                    guess_n  = FIRST_GUESS;
                    steps_n  = '0;
                    result_n = '0;
                end
            end
        endcase
    end

    assign bus.guess  = guess_q;
    assign bus.result = result_q;
    assign bus.steps  = steps_q;
    assign bus.state  = state_q;
    assign bus.busy   = (state_q == SEARCH);
    assign bus.done   = (state_q == DONE);
    assign bus.error  = (state_q == ERR);

endmodule

// File: tb/tb_comp_buscador.sv
module tb_comp_buscador;
    import comp_buscador_pkg::*;

    localparam int N  = 4;
    localparam int CW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT (N=4) with behavioural comparator ----------------
    comp_buscador_if #(.N(N), .CW(CW)) bus ();
    comp_buscador #(.N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0] secret;
    logic         ovr_en;
    logic [2:0]   ovr_flags;

    always_comb begin
        if (ovr_en) begin
            {bus.mayor, bus.igual, bus.menor} = ovr_flags;
        end else begin
            bus.mayor = (secret > bus.guess);
            bus.igual = (secret == bus.guess);
            bus.menor = (secret < bus.guess);
        end
    end

    // ---------------- second DUT (N=2) with Comp2 ----------------
    comp_buscador_if #(.N(2), .CW(2)) bus2 ();
    comp_buscador #(.N(2), .CW(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    logic [1:0] secret2;
    comp2 u_comp2 (
        .a     (secret2),
        .b     (bus2.guess),
        .mayor (bus2.mayor),
        .igual (bus2.igual),
        .menor (bus2.menor)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [N-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one search against the behavioural comparator. exp_q holds the
    // expected guess sequence; start is re-pulsed mid-search at index pulse_at.
    task automatic run_search(input string name, input logic [N-1:0] s,
                              input int exp_steps, input logic [N-1:0] exp_res,
                              input int pulse_at);
        int n;
        logic [N-1:0] g;
        n = exp_q.size();
        secret = s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({name, "_busy0"},   32'(bus.busy),   32'd1);
        check({name, "_done0"},   32'(bus.done),   32'd0);
        check({name, "_steps0"},  32'(bus.steps),  32'd0);
        check({name, "_result0"}, 32'(bus.result), 32'd0);
        for (int i = 0; i < n; i++) begin
            g = exp_q.pop_front();
            check($sformatf("%s_guess%0d", name, i), 32'(bus.guess), 32'(g));
            if (i == pulse_at) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        check({name, "_done"},   32'(bus.done),   32'd1);
        check({name, "_busy"},   32'(bus.busy),   32'd0);
        check({name, "_error"},  32'(bus.error),  32'd0);
        check({name, "_result"}, 32'(bus.result), 32'(exp_res));
        check({name, "_steps"},  32'(bus.steps),  32'(exp_steps));
        tick();
        tick();
        check({name, "_done_hold"},   32'(bus.done),   32'd1);
        check({name, "_result_hold"}, 32'(bus.result), 32'(exp_res));
        check({name, "_steps_hold"},  32'(bus.steps),  32'(exp_steps));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus2.start = 1'b0;
        secret    = '0;
        secret2   = '0;
        ovr_en    = 1'b0;
        ovr_flags = 3'b000;
        tick();
        tick();
        check("rst_guess",  32'(bus.guess),  32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_steps",  32'(bus.steps),  32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_error",  32'(bus.error),  32'd0);
        check("rst_state",  32'(bus.state),  32'd0);
        rst = 1'b0;
        tick();

        exp_q = '{4'd7};
        run_search("s7", 4'd7, 1, 4'd7, -1);

        exp_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        run_search("s15", 4'd15, 5, 4'd15, -1);

        exp_q = '{4'd7, 4'd3, 4'd1, 4'd0};
        run_search("s0", 4'd0, 4, 4'd0, -1);

        exp_q = '{4'd7, 4'd11, 4'd9, 4'd10};
        run_search("s10", 4'd10, 4, 4'd10, -1);

        // Restart directly from DONE.
        exp_q = '{4'd7, 4'd3, 4'd1, 4'd2};
        run_search("s2", 4'd2, 4, 4'd2, -1);

        // start pulsed mid-search must not disturb the sequence.
        exp_q = '{4'd7, 4'd11, 4'd13};
        run_search("s13_startign", 4'd13, 3, 4'd13, 1);

        // mayor and igual together on the first sample.
        ovr_en = 1'b1;
        ovr_flags = 3'b110;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("e_multi_guess", 32'(bus.guess), 32'd7);
        tick();
        check("e_multi_error", 32'(bus.error), 32'd1);
        check("e_multi_busy",  32'(bus.busy),  32'd0);
        check("e_multi_done",  32'(bus.done),  32'd0);
        check("e_multi_steps", 32'(bus.steps), 32'd1);
        tick();
        tick();
        check("e_multi_hold",  32'(bus.error), 32'd1);
        check("e_multi_guess_hold", 32'(bus.guess), 32'd7);
        ovr_en = 1'b0;

        // menor reported while guess == lo; restart from ERR.
        secret = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("e_lo_busy", 32'(bus.busy), 32'd1);
        tick();
        tick();
        tick();
        check("e_lo_guess", 32'(bus.guess), 32'd0);
        ovr_en = 1'b1;
        ovr_flags = 3'b001;
        tick();
        check("e_lo_error", 32'(bus.error), 32'd1);
        check("e_lo_steps", 32'(bus.steps), 32'd4);
        ovr_en = 1'b0;

        // No flag at all.
        ovr_en = 1'b1;
        ovr_flags = 3'b000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("e_none_error", 32'(bus.error), 32'd1);
        check("e_none_steps", 32'(bus.steps), 32'd1);
        ovr_en = 1'b0;

        // Reset in the third SEARCH cycle.
        secret = 4'd15;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("mid_guess", 32'(bus.guess), 32'd13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_guess",  32'(bus.guess),  32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_steps",  32'(bus.steps),  32'd0);
        check("mid_rst_busy",   32'(bus.busy),   32'd0);
        check("mid_rst_done",   32'(bus.done),   32'd0);
        check("mid_rst_error",  32'(bus.error),  32'd0);
        check("mid_rst_state",  32'(bus.state),  32'd0);

        // N=2 instance against Comp2, secret 3: guesses 1, 2, 3.
        secret2 = 2'd3;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("c2_guess0", 32'(bus2.guess), 32'd1);
        tick();
        check("c2_guess1", 32'(bus2.guess), 32'd2);
        tick();
        check("c2_guess2", 32'(bus2.guess), 32'd3);
        tick();
        check("c2_done",   32'(bus2.done),   32'd1);
        check("c2_result", 32'(bus2.result), 32'd3);
        check("c2_steps",  32'(bus2.steps),  32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
